// File: rtl/kmap_pkg.sv
// Shared types and helpers for the K-map minterm extractor.
// Optional compare feature in the top is enabled by defining KMAP_COMPARE_EN.
package kmap_pkg;

  localparam int KMAP_MAX_VARS = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  // Width of a counter that spans 0..settle-1, never narrower than one bit.
  function automatic int settle_w(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/kmap_settle_timer.sv
// Holds each input combination for SETTLE cycles and flags the sample edge.
module kmap_settle_timer
  import kmap_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int W = settle_w(SETTLE);
  localparam logic [W-1:0] LAST = W'(SETTLE - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/kmap_minterm_extractor.sv
// Sweeps all 2^N input combinations and captures f_in into a minterm mask.
// Define KMAP_COMPARE_EN to add the expected/match comparison ports.
module kmap_minterm_extractor
  import kmap_pkg::*;
#(
  parameter int N      = 4,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            f_in,
  output logic [N-1:0]    vars,
  output logic            busy,
  output logic            done,
  output logic [2**N-1:0] mask,
  output logic [N:0]      count
`ifdef KMAP_COMPARE_EN
  ,
  input  logic [2**N-1:0] expected,
  output logic            match
`endif
);

  state_t          state;
  logic            tick;
  logic            sweep_go;
  logic [2**N-1:0] mask_nxt;
`ifdef KMAP_COMPARE_EN
  logic [2**N-1:0] expected_q;
`endif

  // start is only honoured from IDLE; a request during a sweep is dropped.
  assign sweep_go = (state == S_IDLE) && start;

  kmap_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (sweep_go),
    .en    (state == S_SWEEP),
    .tick  (tick)
  );

  always_comb begin
    mask_nxt       = mask;
    mask_nxt[vars] = f_in;
  end

  // NOTE: every register, including the mask, has a reset value so an
  // aborted sweep leaves no stale partial result behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      vars       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mask       <= '0;
      count      <= '0;
`ifdef KMAP_COMPARE_EN
      expected_q <= '0;
      match      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_SWEEP;
            busy       <= 1'b1;
            vars       <= '0;
            mask       <= '0;
            count      <= '0;
`ifdef KMAP_COMPARE_EN
            expected_q <= expected;
            match      <= 1'b0;
`endif
          end
        end
        S_SWEEP: begin
          if (tick) begin
            mask  <= mask_nxt;
            count <= count + (N+1)'(f_in);
            vars  <= vars + 1'b1;
            if (&vars) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
`ifdef KMAP_COMPARE_EN
              match <= (mask_nxt == expected_q);
`endif
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kmap_minterm_extractor.sv
// Self-checking bench: four extractor instances with different N/SETTLE,
// fixed K-map functions plus random truth tables against a table model.
module tb_kmap_minterm_extractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  start = '0;
  logic [15:0] tt     [4];
  logic [15:0] exp_in [4];
  int          n_of   [4] = '{2, 3, 4, 4};
  int          s_of   [4] = '{1, 1, 3, 1};

  wire  [3:0]  busy, done, match;
  wire  [3:0]  vars_w  [4];
  wire  [15:0] mask_w  [4];
  wire  [4:0]  count_w [4];

  wire [1:0] v0; wire [2:0] v1; wire [3:0] v2; wire [3:0] v3;
  wire [3:0] m0; wire [7:0] m1; wire [15:0] m2; wire [15:0] m3;
  wire [2:0] c0; wire [3:0] c1; wire [4:0] c2; wire [4:0] c3;
  wire f0, f1, f2, f3;

  assign f0 = tt[0][v0];
  assign f1 = tt[1][v1];
  assign f2 = tt[2][v2];
  assign f3 = tt[3][v3];

  assign vars_w[0] = 4'(v0);  assign mask_w[0] = 16'(m0);  assign count_w[0] = 5'(c0);
  assign vars_w[1] = 4'(v1);  assign mask_w[1] = 16'(m1);  assign count_w[1] = 5'(c1);
  assign vars_w[2] = v2;      assign mask_w[2] = m2;       assign count_w[2] = c2;
  assign vars_w[3] = v3;      assign mask_w[3] = m3;       assign count_w[3] = c3;

`ifndef KMAP_COMPARE_EN
  assign match = '0;
`endif

  kmap_minterm_extractor #(.N(2), .SETTLE(1)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .f_in(f0), .vars(v0),
    .busy(busy[0]), .done(done[0]), .mask(m0), .count(c0)
`ifdef KMAP_COMPARE_EN
    , .expected(exp_in[0][3:0]), .match(match[0])
`endif
  );

  kmap_minterm_extractor #(.N(3), .SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .f_in(f1), .vars(v1),
    .busy(busy[1]), .done(done[1]), .mask(m1), .count(c1)
`ifdef KMAP_COMPARE_EN
    , .expected(exp_in[1][7:0]), .match(match[1])
`endif
  );

  kmap_minterm_extractor #(.N(4), .SETTLE(3)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .f_in(f2), .vars(v2),
    .busy(busy[2]), .done(done[2]), .mask(m2), .count(c2)
`ifdef KMAP_COMPARE_EN
    , .expected(exp_in[2]), .match(match[2])
`endif
  );

  kmap_minterm_extractor #(.N(4), .SETTLE(1)) u3 (
    .clk(clk), .rst(rst), .start(start[3]), .f_in(f3), .vars(v3),
    .busy(busy[3]), .done(done[3]), .mask(m3), .count(c3)
`ifdef KMAP_COMPARE_EN
    , .expected(exp_in[3]), .match(match[3])
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Truth tables of the K-map example functions, from their Boolean forms.
  function automatic logic [15:0] tt_of(input int id);
    logic [15:0] t = '0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] b = 4'(i);
      case (id)
        0: t[i] = b[1] ^ b[0];                                         // A^B
        1: t[i] = (~b[2] & b[1] & ~b[0]) | (~b[1] & b[0]) | (b[2] & b[0]); // A'BC'+B'C+AC
        2: t[i] = (~b[2] & ~b[0]) | (b[2] & b[0]);                     // B'D'+BD
        default: t[i] = 1'b1;
      endcase
    end
    return t;
  endfunction

  // One sweep on instance k; poke >= 0 raises start for one edge mid-sweep.
  task automatic sweep(input int k, input logic [15:0] f, input logic [15:0] e,
                       input int poke, input string tag);
    int          n   = n_of[k];
    int          s   = s_of[k];
    int          lim = (1 << n) * s;
    int          lat = 0;
    bit          vok = 1'b1;
    bit          got = 1'b0;
    logic [15:0] sel = (n == 4) ? 16'hFFFF : 16'((32'd1 << (1 << n)) - 1);
    logic [15:0] em  = f & sel;
    tt[k]     = f;
    exp_in[k] = e;
    @(negedge clk); start[k] = 1'b1;
    @(posedge clk); #1; start[k] = 1'b0;
    check({tag, "_start"}, {busy[k], done[k]}, 2'b10);
    while (!got && lat < lim + 10) begin
      if (vars_w[k] != 4'((lat / s) % (1 << n))) vok = 1'b0;
      if (lat == poke) start[k] = 1'b1;
      @(posedge clk); #1; start[k] = 1'b0; lat++;
      got = done[k];
    end
    if (vars_w[k] != 4'd0) vok = 1'b0;
    check({tag, "_latency"}, lat, lim);
    check({tag, "_vars_seq"}, vok, 1);
    check({tag, "_mask"}, mask_w[k], em);
    check({tag, "_count"}, count_w[k], $countones(em));
    check({tag, "_busy_end"}, busy[k], 0);
`ifdef KMAP_COMPARE_EN
    check({tag, "_match"}, match[k], em == (e & sel));
`endif
  endtask

  task automatic no_done(input int k, input int cycles, input string tag);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done[k]) pulses++;
    end
    check({tag, "_no_done"}, pulses, 0);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      tt[k] = '0; exp_in[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      check($sformatf("reset_%0d", k),
            {vars_w[k], busy[k], done[k], mask_w[k], count_w[k], match[k]}, 0);
    @(negedge clk); rst = 1'b0;

    sweep(0, tt_of(0), 16'h0006, -1, "xor_n2");
    check("xor_n2_plan", {mask_w[0], count_w[0]}, {16'h0006, 5'd2});

    sweep(1, tt_of(1), 16'h00A6, -1, "sop_n3");
    check("sop_n3_plan", {mask_w[1], count_w[1]}, {16'h00A6, 5'd4});

    sweep(2, tt_of(2), 16'hA5A5, -1, "bd_s3");
    check("bd_s3_plan", {mask_w[2], count_w[2]}, {16'hA5A5, 5'd8});
`ifdef KMAP_COMPARE_EN
    check("bd_match_hit", match[2], 1);
`endif
    sweep(2, tt_of(2), 16'hA5A4, -1, "bd_s3_miss");
`ifdef KMAP_COMPARE_EN
    check("bd_match_miss", match[2], 0);
`endif

    sweep(3, tt_of(3), 16'hFFFF, 7, "ones_poke");
    check("ones_plan", {mask_w[3], count_w[3]}, {16'hFFFF, 5'd16});
    no_done(3, 40, "ones_poke");
    // start held high on the final sample edge must not chain a new sweep
    sweep(3, tt_of(3), 16'hFFFF, 15, "ones_last");
    no_done(3, 40, "ones_last");

    // back-to-back: second sweep starts in the first IDLE cycle
    sweep(0, 16'h0009, 16'h0009, -1, "b2b_a");
    sweep(0, 16'h0003, 16'h0000, -1, "b2b_b");

    // reset mid-sweep
    tt[3] = 16'($urandom);
    @(negedge clk); start[3] = 1'b1;
    @(posedge clk); #1; start[3] = 1'b0;
    repeat (4) @(posedge clk);
    #2; rst = 1'b1;
    @(posedge clk); #1;
    check("abort_outputs",
          {vars_w[3], busy[3], done[3], mask_w[3], count_w[3], match[3]}, 0);
    @(negedge clk); rst = 1'b0;
    no_done(3, 30, "abort");
    sweep(3, tt_of(2), 16'h1234, -1, "after_abort");

    for (int r = 0; r < 8; r++) begin
      int          k = int'($urandom_range(0, 3));
      logic [15:0] f = 16'($urandom);
      logic [15:0] e = ($urandom_range(0, 1) == 1) ? f : f ^ (16'd1 << $urandom_range(0, 3));
      sweep(k, f, e, -1, $sformatf("rand%0d_k%0d", r, k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/kmap_minterm_extractor.md
# kmap_minterm_extractor

Sequential truth-table reader: sweeps every input combination of an N-variable combinational function and captures its output into a minterm mask, the Σ(...) notation. Minimisation goes from minterm list to gates; this block goes from gates back to the minterm list. It sits beside the K-map example modules as a self-checking harness: `vars` drives the function under test and `f_in` returns its output.

## Interface
Parameters:
- `N`, default 4: number of input variables, legal 2..4.
- `SETTLE`, default 1: cycles each combination is held before sampling, legal ≥1.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request a sweep; sampled on `clk`.
- `f_in`  in  1  output of the function under test.
- `vars`  out  N  current input combination; `vars[N-1]` = A (MSB), `vars[0]` = last variable.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse when the mask is final.
- `mask`  out  2^N  bit i = F(i).
- `count`  out  N+1  number of minterms, the popcount of `mask`.

## Operation
- FSM has two states:
  - IDLE: outputs hold the last results.
  - SWEEP: stepping through combinations.
- IDLE → SWEEP when `start`=1 at an edge:
  - `mask` and `count` clear to 0.
  - `vars` goes to 0.
  - The settle counter clears.
- In SWEEP:
  - The settle counter counts 0..SETTLE-1.
  - At the edge where it equals SETTLE-1, `f_in` is written to `mask[vars]` and `count` increments if `f_in`=1.
  - At that same edge, `vars` increments and the settle counter clears.
- At the sample edge with `vars`=2^N-1:
  - FSM → IDLE, `done`=1 for exactly one cycle.
  - `vars` wraps to 0.
  - `mask` and `count` hold until the next accepted `start`.
- `start` is ignored while `busy`=1, including on the final sample edge. A `start` already high in the first IDLE cycle begins a new sweep.
- `count` width N+1 holds 2^N (all-ones function) without overflow.

## Timing
- Reset values: `vars`=0, `busy`=0, `done`=0, `mask`=0, `count`=0, FSM=IDLE.
- Reset asserted mid-sweep aborts immediately. The partial mask is discarded, and no `done` pulse is produced.
- `start` sampled high at edge e0:
  - `busy`=1 from e0.
  - The sample for index i occurs at edge e0+(i+1)·SETTLE.
  - At edge e0+2^N·SETTLE, `busy`=0 and `done`=1 (cleared at the next edge).
- Total latency from `start` to `done` is 2^N·SETTLE cycles. Example: N=4, SETTLE=1 gives 16 cycles.
- `vars` is registered and stable for exactly SETTLE cycles per index. `f_in` must be valid within SETTLE cycles of a `vars` change.
- Back-to-back: minimum gap between sweeps is 1 IDLE cycle.

## Configuration
- `KMAP_COMPARE_EN` defined:
  - Adds input `expected` [2^N-1:0] and output `match` (1 bit, reset 0).
  - `expected` is sampled at the accepted `start`.
  - `match` is updated at the `done` edge to (`mask` == latched `expected`) and held until the next `start`, which clears it to 0.
- Undefined: neither port exists, and there is no comparison logic.

## Structure
- Package `kmap_pkg` holds:
  - the state enum (`S_IDLE`, `S_SWEEP`);
  - `KMAP_MAX_VARS`=4;
  - the `clog2`-based settle-counter width helper.
- One natural sub-module, `kmap_settle_timer`:
  - contains the SETTLE-cycle down/up counter;
  - emits a `tick` on the sample edge;
  - is cleared by the sweep start.
- The rest (FSM, `vars` counter, mask/count registers) lives in the top module.

## Test plan
- N=2, SETTLE=1, `f_in`=A^B:
  - `start` → `done` after 4 cycles, `mask`=4'b0110, `count`=2.
- N=3, `f_in`=A'BC'+B'C+AC:
  - `mask`=8'hA6, `count`=4.
- N=4, SETTLE=3, `f_in`=B'D'+BD:
  - `done` exactly 48 cycles after `start`, `mask`=16'hA5A5, `count`=8.
  - `vars` is observed stable for 3 cycles per index.
- N=4, `f_in`=1:
  - `mask`=16'hFFFF, `count`=16.
  - Then `start` pulsed mid-sweep is ignored, and a single `done` occurs.
- `rst` at cycle 5 of a sweep:
  - all outputs 0 on the next cycle, no `done`;
  - a fresh `start` yields the correct mask.
- With `KMAP_COMPARE_EN`, N=4:
  - `expected`=16'hA5A5 against B'D'+BD → `match`=1;
  - `expected`=16'hA5A4 → `match`=0.
